// File: rtl/median_image_writer_pkg.sv
// Shared geometry and writer state encoding for the binary median-filter path.
// Common to the window reader and the result image writer.
package median_image_writer_pkg;

  localparam int unsigned IMAGEWIDTH  = 240;
  localparam int unsigned IMAGEHEIGHT = 180;
  localparam int unsigned WINDOWSIZE  = 3;
  localparam int unsigned WORDWIDTH   = 8;

  localparam int unsigned OUTW        = IMAGEWIDTH - WINDOWSIZE + 1;
  localparam int unsigned OUTH        = IMAGEHEIGHT - WINDOWSIZE + 1;
  localparam int unsigned WORDSPERCOL = (OUTH + WORDWIDTH - 1) / WORDWIDTH;
  localparam int unsigned LASTBITS    = OUTH % WORDWIDTH;

  localparam int unsigned ADDRW = $clog2(OUTW * WORDSPERCOL);
  localparam int unsigned XW    = $clog2(OUTW);
  localparam int unsigned WIW   = $clog2(WORDSPERCOL);
  localparam int unsigned BITW  = $clog2(WORDWIDTH);

  // Bit index of the final pixel in a column's last word.
  localparam int unsigned LASTBITIDX = (LASTBITS == 0) ? WORDWIDTH - 1 : LASTBITS - 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } writer_state_e;

  function automatic logic [ADDRW-1:0] word_addr(input logic [XW-1:0]  x,
                                                  input logic [WIW-1:0] w);
    return ADDRW'(x) * ADDRW'(WORDSPERCOL) + ADDRW'(w);
  endfunction

endpackage

// File: rtl/median_bit_packer.sv
// Packs successive 1-bit filter results into a word, LSB = lowest image row.
// The presented word already includes the bit accepted this cycle.
module median_bit_packer
  import median_image_writer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 accept,
  input  logic                 bit_in,
  input  logic                 col_end,
  output logic [WORDWIDTH-1:0] word,
  output logic                 word_ready,
  output logic [BITW-1:0]      bit_idx
);

  logic [WORDWIDTH-1:0] pack_q;
  logic [BITW-1:0]      bit_idx_q;

  assign bit_idx    = bit_idx_q;
  assign word_ready = accept && ((bit_idx_q == BITW'(WORDWIDTH - 1)) || col_end);

  always_comb begin
    word = pack_q;
    if (accept) begin
      word[bit_idx_q] = bit_in;
    end
  end

  // Clearing on completion keeps the unused high bits of a short column word at 0.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      pack_q    <= '0;
      bit_idx_q <= '0;
    end else if (accept) begin
      if (word_ready) begin
        pack_q    <= '0;
        bit_idx_q <= '0;
      end else begin
        pack_q    <= word;
        bit_idx_q <= bit_idx_q + BITW'(1);
      end
    end
  end

endmodule

// File: rtl/median_image_writer.sv
// Writes the packed median-filter result stream into the result image RAM.
// Optional MEDIAN_WRITER_ACTIVE_COUNT_EN builds a saturating count of 1-pixels.
module median_image_writer
  import median_image_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        start,
  input  logic        dataIn,
  input  logic        dataValid,
  output logic [12:0] wrAddressOut,
  output logic [7:0]  wrDataOut,
  output logic        wrEnOut,
  output logic        frameDone,
  output logic [15:0] activePixels
);

  writer_state_e        state_q;
  logic [XW-1:0]        x_q;
  logic [WIW-1:0]       word_idx_q;
  logic                 accept;
  logic                 col_end;
  logic                 last_col;
  logic [WORDWIDTH-1:0] word;
  logic                 word_ready;
  logic [BITW-1:0]      bit_idx;

  assign accept   = start && dataValid && (state_q == StRun);
  // The row position is implied by word index and bit index, so no separate y counter.
  assign col_end  = (word_idx_q == WIW'(WORDSPERCOL - 1)) && (bit_idx == BITW'(LASTBITIDX));
  assign last_col = (x_q == XW'(OUTW - 1));

  median_bit_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .accept     (accept),
    .bit_in     (dataIn),
    .col_end    (col_end),
    .word       (word),
    .word_ready (word_ready),
    .bit_idx    (bit_idx)
  );

  always_ff @(posedge clk) begin
    if (reset || init) begin
      state_q      <= StIdle;
      x_q          <= '0;
      word_idx_q   <= '0;
      wrEnOut      <= 1'b0;
      wrAddressOut <= '0;
      wrDataOut    <= '0;
      frameDone    <= 1'b0;
    end else if (!start) begin
      wrEnOut <= 1'b0;
    end else begin
      wrEnOut <= word_ready;
      unique case (state_q)
        StIdle: state_q <= StRun;
        StRun: begin
          if (word_ready) begin
            wrDataOut    <= word;
            wrAddressOut <= word_addr(x_q, word_idx_q);
            if (col_end) begin
              word_idx_q <= '0;
              if (last_col) begin
                state_q   <= StDone;
                frameDone <= 1'b1;
              end else begin
                x_q <= x_q + XW'(1);
              end
            end else begin
              word_idx_q <= word_idx_q + WIW'(1);
            end
          end
        end
        StDone: state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEDIAN_WRITER_ACTIVE_COUNT_EN
  logic [15:0] active_q;

  always_ff @(posedge clk) begin
    if (reset || init) begin
      active_q <= '0;
    end else if (accept && dataIn && (active_q != 16'hFFFF)) begin
      active_q <= active_q + 16'd1;
    end
  end

  assign activePixels = active_q;
`else
  assign activePixels = '0;
`endif

endmodule

// File: tb/tb_median_image_writer.sv
// Bench for median_image_writer: scoreboard of expected RAM writes derived from pixel positions,
// plus a vector table and directed sequences for stall, column end, abort and full frame.
module tb_median_image_writer;

  localparam int OUTW  = 238;
  localparam int OUTH  = 178;
  localparam int WPC   = (OUTH + 7) / 8;
  localparam int TOTAL = OUTW * OUTH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic        start = 1'b0;
  logic        dataIn = 1'b0;
  logic        dataValid = 1'b0;
  logic [12:0] wrAddressOut;
  logic [7:0]  wrDataOut;
  logic        wrEnOut;
  logic        frameDone;
  logic [15:0] activePixels;

  median_image_writer dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .start        (start),
    .dataIn       (dataIn),
    .dataValid    (dataValid),
    .wrAddressOut (wrAddressOut),
    .wrDataOut    (wrDataOut),
    .wrEnOut      (wrEnOut),
    .frameDone    (frameDone),
    .activePixels (activePixels)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int addr;
    int data;
    int due;
    bit last;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  // Reference model: frame position k of accepted pixels, 0 idle / 1 run / 2 done.
  int m_state = 0;
  int k = 0;
  int cur = 0;
  int m_active = 0;

  int wr_count = 0;
  int last_addr = -1;
  int last_data = -1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp,
               exp, $time);
    end
  endtask

  function automatic int exp_act(input int v);
`ifdef MEDIAN_WRITER_ACTIVE_COUNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic void model_accept(input logic d, input int due);
    int x;
    int y;
    wr_t e;
    x = k / OUTH;
    y = k % OUTH;
    if (d) begin
      cur = cur | (1 << (y % 8));
      if (m_active < 65535) m_active++;
    end
    if ((y % 8 == 7) || (y == OUTH - 1)) begin
      e.addr = x * WPC + y / 8;
      e.data = cur;
      e.due  = due;
      e.last = (k == TOTAL - 1);
      exp_q.push_back(e);
      cur = 0;
    end
    k++;
    if (k == TOTAL) m_state = 2;
  endfunction

  // One clock: drive inputs, let the DUT take the edge, then advance the model.
  task automatic tick(input logic s, input logic v, input logic d, input logic i);
    int due;
    start     = s;
    dataValid = v;
    dataIn    = d;
    init      = i;
    due = edge_no + 1;
    @(posedge clk);
    #1;
    if (reset || i) begin
      m_state  = 0;
      k        = 0;
      cur      = 0;
      m_active = 0;
      exp_q.delete();
    end else if (s) begin
      if (m_state == 0) m_state = 1;
      else if (m_state == 1 && v) model_accept(d, due);
    end
  endtask

  task automatic send(input logic d);
    tick(1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (wrEnOut === 1'b1) begin
      wr_count++;
      last_addr = int'(wrAddressOut);
      last_data = int'(wrDataOut);
      if (exp_q.size() == 0) begin
        check("spurious_write", wrEnOut, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wrAddressOut, mon_e.addr);
        check("wr_data", wrDataOut, mon_e.data);
        check("wr_latency", edge_no, mon_e.due);
        check("frame_done_at_write", frameDone, mon_e.last);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= edge_no) begin
      check("missing_write", wrEnOut, 1);
      void'(exp_q.pop_front());
    end
  end

  typedef struct {
    logic [7:0] seq;   // sent MSB first
    int         addr;
    logic [7:0] data;
    int         active;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   wr0;
    int   sent;
    int   r;
    int   act_hold;
    logic [7:0] s;

    tbl[0] = '{8'b1011_0001, 0, 8'h8D, 4};
    tbl[1] = '{8'b0000_0000, 1, 8'h00, 4};
    tbl[2] = '{8'b1111_1111, 2, 8'hFF, 12};
    tbl[3] = '{8'b1100_1010, 3, 8'h53, 16};
    tbl[4] = '{8'b0000_0001, 4, 8'h80, 17};

    // Reset
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    check("rst_wren", wrEnOut, 0);
    check("rst_addr", wrAddressOut, 0);
    check("rst_data", wrDataOut, 0);
    check("rst_frame_done", frameDone, 0);
    check("rst_active", activePixels, 0);

    // Valids while idle (start low) are ignored
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("idle_no_write", wr_count, 0);
    check("idle_active", activePixels, 0);

    // Start; a valid on the IDLE->RUN cycle is dropped
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    wr0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      s = tbl[i].seq;
      for (int j = 7; j >= 0; j--) send(s[j]);
      idle(1);
      check("tbl_wr_count", wr_count - wr0, i + 1);
      check("tbl_addr", last_addr, tbl[i].addr);
      check("tbl_data", last_data, tbl[i].data);
      check("tbl_active", activePixels, exp_act(tbl[i].active));
      check("tbl_frame_done", frameDone, 0);
    end

    // Stall mid-word: pulsed valids with start low are dropped
    wr0 = wr_count;
    send(1'b1);
    send(1'b1);
    send(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      check("stall_wren", wrEnOut, 0);
    end
    send(1'b0);
    send(1'b0);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    idle(1);
    check("stall_wr_count", wr_count - wr0, 1);
    check("stall_addr", last_addr, 5);
    check("stall_data", last_data, 8'hA3);
    check("stall_active", activePixels, exp_act(21));

    // Column end: 178 ones -> 22 full words then a 2-bit word
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    wr0 = wr_count;
    for (int i = 0; i < OUTH; i++) send(1'b1);
    idle(1);
    check("col_wr_count", wr_count - wr0, WPC);
    check("col_last_addr", last_addr, 22);
    check("col_last_data", last_data, 8'h03);
    for (int i = 0; i < 8; i++) send(1'b1);
    idle(1);
    check("col_next_addr", last_addr, 23);
    check("col_next_data", last_data, 8'hFF);

    // Abort after 100 valids: no partial write, all outputs clear
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    wr0 = wr_count;
    for (int i = 0; i < 100; i++) send(1'($urandom));
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("abort_wren", wrEnOut, 0);
    check("abort_addr", wrAddressOut, 0);
    check("abort_data", wrDataOut, 0);
    check("abort_frame_done", frameDone, 0);
    check("abort_active", activePixels, 0);
    idle(2);
    check("abort_wr_count", wr_count - wr0, 12);
    for (int i = 0; i < 8; i++) send(1'($urandom));
    idle(1);
    check("restart_addr", last_addr, 0);
    check("restart_wr_count", wr_count - wr0, 13);

    // Full frame with random data, gaps and stalls
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    wr0 = wr_count;
    sent = 0;
    while (sent < TOTAL) begin
      r = int'($urandom_range(15, 0));
      if (r == 0) begin
        tick(1'b1, 1'b0, 1'b0, 1'b0);
      end else if (r == 1) begin
        tick(1'b0, 1'b1, 1'($urandom), 1'b0);
      end else begin
        send(1'($urandom));
        sent++;
      end
    end
    idle(1);
    check("frame_wr_count", wr_count - wr0, OUTW * WPC);
    check("frame_last_addr", last_addr, 5473);
    check("frame_done", frameDone, 1);
    check("frame_active", activePixels, exp_act(m_active));
    act_hold = int'(activePixels);
    wr0 = wr_count;
    for (int i = 0; i < 20; i++) send(1'b1);
    idle(1);
    check("done_no_write", wr_count - wr0, 0);
    check("done_sticky", frameDone, 1);
    check("done_active_hold", activePixels, act_hold);
    check("pending_writes", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
